// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - registered hex nibble to active-low seven-segment decoder
// Segment order in OUT is {g,f,e,d,c,b,a}; a 0 lights the segment.
module seven_seg (
    input  logic       I_CLOCK,
    input  logic       I_RESET,
    input  logic [3:0] IN,
    output logic [6:0] OUT
);

    logic [6:0] seg_next;

    always_comb begin
        seg_next = 7'h7F;
        unique case (IN)
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hA: seg_next = 7'h08;
            4'hB: seg_next = 7'h03;
            4'hC: seg_next = 7'h46;
            4'hD: seg_next = 7'h21;
            4'hE: seg_next = 7'h06;
            4'hF: seg_next = 7'h0E;
        endcase
    end

    // Falling-edge register keeps the digit stable while the pipeline updates on the rising edge.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            OUT <= 7'h7F;
        end else begin
            OUT <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg.sv
// tb/tb_seven_seg.sv - directed self-checking bench for seven_seg
module tb_seven_seg;

    logic        clk;
    logic        rst;
    logic [15:0] hex_in;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int checks;
    int failures;

    logic [6:0] exp_tab [16];

    seven_seg u_hex0 (.I_CLOCK(clk), .I_RESET(rst), .IN(hex_in[3:0]),   .OUT(hex0));
    seven_seg u_hex1 (.I_CLOCK(clk), .I_RESET(rst), .IN(hex_in[7:4]),   .OUT(hex1));
    seven_seg u_hex2 (.I_CLOCK(clk), .I_RESET(rst), .IN(hex_in[11:8]),  .OUT(hex2));
    seven_seg u_hex3 (.I_CLOCK(clk), .I_RESET(rst), .IN(hex_in[15:12]), .OUT(hex3));

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, want);
        end
    endtask

    task automatic fall_tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        rst    = 1'b1;
        hex_in = 16'h0008;
        fall_tick();
        check_val("reset_edge1", hex0, 7'h7F);
        fall_tick();
        check_val("reset_edge2", hex0, 7'h7F);
        check_val("reset_hex3", hex3, 7'h7F);

        rst = 1'b0;
        fall_tick();
        check_val("reset_release_8", hex0, 7'h00);

        for (int i = 0; i < 16; i++) begin
            hex_in = {12'h000, 4'(i)};
            fall_tick();
            check_val($sformatf("sweep_%0h", i), hex0, exp_tab[i]);
        end

        hex_in = 16'h0001;
        fall_tick();
        check_val("hold_pre_1", hex0, 7'h79);
        hex_in = 16'h0007;
        @(posedge clk);
        #1;
        check_val("hold_rise_no_change", hex0, 7'h79);
        fall_tick();
        check_val("hold_next_7", hex0, 7'h78);

        hex_in = 16'h000E;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_between_edges", hex0, 7'h78);
        fall_tick();
        check_val("reset_priority_E", hex0, 7'h7F);
        rst = 1'b0;

        hex_in = 16'h0005;
        fall_tick();
        check_val("mid_reset_5", hex0, 7'h12);
        hex_in = 16'h0006;
        rst    = 1'b1;
        fall_tick();
        check_val("mid_reset_6", hex0, 7'h7F);
        rst    = 1'b0;
        hex_in = 16'h0009;
        fall_tick();
        check_val("mid_reset_9", hex0, 7'h10);

        hex_in = 16'hDEAD;
        fall_tick();
        check_val("int_hex3", hex3, 7'h21);
        check_val("int_hex2", hex2, 7'h06);
        check_val("int_hex1", hex1, 7'h08);
        check_val("int_hex0", hex0, 7'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg.md
# seven_seg

Registered hexadecimal-to-seven-segment decoder for the board's HEX displays. Each instance takes one 4-bit nibble and drives one active-low 7-segment digit. The Memory stage uses four instances on the 16-bit memory-mapped HEX register (address 0x3FE): nibble [15:12] drives HEX3 and nibble [3:0] drives HEX0. The output is registered on the pipeline's falling clock edge, so digits change cleanly with no combinational glitches.

## Interface
- No parameters.
- I_CLOCK  input  1  pipeline clock; all state updates on the falling edge.
- I_RESET  input  1  synchronous reset, active-high, sampled on the falling edge of I_CLOCK.
- IN  input  4  hex nibble to display (0x0–0xF).
- OUT  output  7  segment drive, active-low (0 = segment lit). Bit map: OUT[0]=a (top), [1]=b (top-right), [2]=c (bottom-right), [3]=d (bottom), [4]=e (bottom-left), [5]=f (top-left), [6]=g (middle).

## Operation
- Every falling edge of I_CLOCK:
  - If I_RESET=1, OUT <= 7'h7F (blank, all segments off).
  - Otherwise, OUT <= decode(IN).
- decode(IN) gives OUT[6:0], active-low:
  - 0→0x40, 1→0x79, 2→0x24, 3→0x30
  - 4→0x19, 5→0x12, 6→0x02, 7→0x78
  - 8→0x00, 9→0x10, A→0x08, b→0x03
  - C→0x46, d→0x21, E→0x06, F→0x0E
- Letters use the conventional glyphs: uppercase A, C, E, F; lowercase b, d.
- The decode is total over the 4-bit input; there is no default or illegal case.
- If IN contains X or Z in simulation, OUT is allowed to go to X. Synthesis treats the decode as a full case.
- No enable, no blanking input, no decimal point. To blank a digit, assert I_RESET.
- Outputs come straight from flops; there is no combinational path from IN to OUT.

## Timing
- Latency: 1 falling edge. A value applied to IN before falling edge n appears on OUT immediately after edge n.
- Throughput: one new nibble per clock; OUT holds its value between edges.
- Reset: synchronous, so it takes effect only on a falling edge.
  - I_RESET asserted between edges has no effect until the next falling edge.
  - Reset overrides IN whenever both are applied at the same edge.
- Reset release: on the first falling edge with I_RESET=0, OUT shows decode(IN) for the IN present at that edge.
- Power-up, before the first edge: OUT is undefined. The integrator must assert I_RESET for at least one falling edge.
- Changes to IN between falling edges never affect OUT.

## Test plan
- Reset: hold I_RESET=1 with IN=0x8 for two falling edges → OUT=0x7F after each edge. Release reset with IN=0x8 → OUT=0x00 after the next falling edge.
- Full sweep: I_RESET=0, step IN through 0x0..0xF, one value per cycle → after each falling edge OUT matches the decode list (for example IN=0x3→0x30, IN=0xA→0x08, IN=0xF→0x0E).
- Latency and hold: change IN from 0x1 to 0x7 just after a falling edge → OUT stays 0x79 until the next falling edge, then becomes 0x78. A rising edge alone does not change OUT.
- Reset priority: with IN=0xE, assert I_RESET at the same edge IN would be captured → OUT=0x7F, not 0x06.
- Mid-operation reset: stream IN=0x5, then 0x6, then 0x9, asserting I_RESET for one edge during 0x6 → OUT sequence 0x12, 0x7F, 0x10.
- Integration: four instances fed 16'hDEAD, with 0xD on IN[15:12], 0xE on IN[11:8], 0xA on IN[7:4] and 0xD on IN[3:0] → after one falling edge HEX3=0x21, HEX2=0x06, HEX1=0x08, HEX0=0x21.
